// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants. The timing generator and the vga_out
// consumers both import this package.
//   pix_cnt_t : 10-bit pixel/line counter type
//   in_range  : inclusive range test used to decode the sync windows
package vga_timing_pkg;

    localparam int H_DISP  = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_DISP  = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int CNT_W   = 10;

    typedef logic [CNT_W-1:0] pix_cnt_t;

    function automatic logic in_range(input pix_cnt_t v, input pix_cnt_t lo, input pix_cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divide-by-4 pixel enable: 25 MHz pixel rate derived from the 100 MHz clock.
//   clk    : system clock
//   reset  : synchronous, active-high; restarts the divider at 0
//   p_tick : high for one clk in every 4 (when the divider reads 3)
module pixel_tick_div (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    logic [1:0] r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= 2'd0;
        end else begin
            r_tick <= r_tick + 2'd1;
        end
    end

    assign p_tick = (r_tick == 2'd3);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Walks a pixel/line counter pair at the pixel
// rate and decodes sync, blanking and end-of-frame from it.
//   clk       : 100 MHz system clock
//   reset     : synchronous, active-high
//   p_tick    : pixel-rate enable (1 clk in 4)
//   hsync     : horizontal sync, active-low
//   vsync     : vertical sync, active-low
//   video_on  : current pixel is inside the visible area
//   pix_x     : current pixel column
//   pix_y     : current line
//   frame_end : one-clk pulse on the last pixel tick of the frame
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP = vga_timing_pkg::H_DISP,
    parameter int H_FP   = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP   = vga_timing_pkg::H_BP,
    parameter int V_DISP = vga_timing_pkg::V_DISP,
    parameter int V_FP   = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP   = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_end
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam pix_cnt_t X_LAST   = pix_cnt_t'(H_TOT - 1);
    localparam pix_cnt_t Y_LAST   = pix_cnt_t'(V_TOT - 1);
    localparam pix_cnt_t X_VIS    = pix_cnt_t'(H_DISP);
    localparam pix_cnt_t Y_VIS    = pix_cnt_t'(V_DISP);
    localparam pix_cnt_t HS_START = pix_cnt_t'(H_DISP + H_FP);
    localparam pix_cnt_t HS_END   = pix_cnt_t'(H_DISP + H_FP + H_SYNC - 1);
    localparam pix_cnt_t VS_START = pix_cnt_t'(V_DISP + V_FP);
    localparam pix_cnt_t VS_END   = pix_cnt_t'(V_DISP + V_FP + V_SYNC - 1);

    logic     w_p_tick;
    logic     w_x_wrap;
    pix_cnt_t w_x_next;
    pix_cnt_t w_y_next;
    pix_cnt_t r_x;
    pix_cnt_t r_y;
    logic     r_hsync;
    logic     r_vsync;
    logic     r_video_on;

    pixel_tick_div u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_p_tick)
    );

    assign w_x_wrap = w_p_tick && (r_x == X_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            w_x_next = w_x_wrap ? '0 : r_x + pix_cnt_t'(1);
            if (w_x_wrap) begin
                w_y_next = (r_y == Y_LAST) ? '0 : r_y + pix_cnt_t'(1);
            end
        end
    end

    // Sync/blank flops are decoded from the next-state counters so they land
    // in the same cycle as the counter value they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= ~in_range(w_x_next, HS_START, HS_END);
            r_vsync    <= ~in_range(w_y_next, VS_START, VS_END);
            r_video_on <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
        end
    end

    assign p_tick    = w_p_tick;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign video_on  = r_video_on;
    assign pix_x     = r_x;
    assign pix_y     = r_y;
    assign frame_end = w_x_wrap && (r_y == Y_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down instance for frame-level behaviour
// and a default 640x480 instance for line-level timing.
module tb_vga_timing_gen;

    // scaled raster: 20 pixels x 13 lines, 80 clk per line, 1040 clk per frame
    localparam int SH_DISP = 10, SH_FP = 3, SH_SYNC = 4, SH_BP = 3;
    localparam int SV_DISP = 6,  SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int S_FRAME = 1040;

    localparam int EV_VID_RISE = 0, EV_VID_FALL = 1, EV_HS_FALL = 2, EV_HS_RISE = 3;
    localparam int EV_VS_FALL  = 4, EV_VS_RISE  = 5, EV_Y_CHG   = 6, EV_FE_RISE = 7;
    localparam int EV_FE_FALL  = 8, EV_Y_WRAP   = 9;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_end;
    logic [9:0] s_x, s_y;
    logic       f_p_tick, f_hsync, f_vsync, f_video_on, f_frame_end;
    logic [9:0] f_x, f_y;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP(SH_DISP), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_DISP(SV_DISP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) u_dut (
        .clk(clk), .reset(reset), .p_tick(s_p_tick), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_video_on), .pix_x(s_x), .pix_y(s_y), .frame_end(s_frame_end)
    );

    vga_timing_gen u_dut_full (
        .clk(clk), .reset(reset), .p_tick(f_p_tick), .hsync(f_hsync), .vsync(f_vsync),
        .video_on(f_video_on), .pix_x(f_x), .pix_y(f_y), .frame_end(f_frame_end)
    );

    // {p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_end}
    function automatic logic [24:0] s_vec();
        return {s_p_tick, s_x, s_y, s_video_on, s_hsync, s_vsync, s_frame_end};
    endfunction

    function automatic logic [24:0] f_vec();
        return {f_p_tick, f_x, f_y, f_video_on, f_hsync, f_vsync, f_frame_end};
    endfunction

    // one reset edge, then release; returns at the negedge before edge 1
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] q[$];
        logic [24:0] exp_v;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_v = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        total++;
        if (s_vec() !== exp_v) begin
            bad++;
            $display("FAIL reset_state_scaled got=%h exp=%h", s_vec(), exp_v);
        end
        total++;
        if (f_vec() !== exp_v) begin
            bad++;
            $display("FAIL reset_state_full got=%h exp=%h", f_vec(), exp_v);
        end
        reset = 1'b0;
        // after edge k: divider reads k%4, pix_x advanced floor(k/4) times
        for (int k = 1; k <= 9; k++)
            q.push_back({(k % 4 == 3), 10'(k / 4), 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        for (int k = 1; q.size() > 0; k++) begin
            @(negedge clk);
            exp_v = q.pop_front();
            total++;
            if (s_vec() !== exp_v) begin
                bad++;
                $display("FAIL release_scaled edge=%0d got=%h exp=%h", k, s_vec(), exp_v);
            end
            total++;
            if (f_vec() !== exp_v) begin
                bad++;
                $display("FAIL release_full edge=%0d got=%h exp=%h", k, f_vec(), exp_v);
            end
        end
    endtask

    task automatic test_line();
        ev_t q[$];
        ev_t obs[$];
        ev_t o, x;
        int y_chg[$];
        logic pv, ph;
        logic [9:0] py;
        pulse_reset();
        pv = f_video_on;
        ph = f_hsync;
        py = f_y;
        q.push_back('{EV_VID_RISE, 1});
        for (int l = 0; l < 2; l++) begin
            q.push_back('{EV_VID_FALL, 3200 * l + 4 * 640});
            q.push_back('{EV_HS_FALL,  3200 * l + 4 * 656});
            q.push_back('{EV_HS_RISE,  3200 * l + 4 * 752});
            q.push_back('{EV_VID_RISE, 3200 * l + 3200});
            q.push_back('{EV_Y_CHG,    3200 * l + 3200});
        end
        for (int e = 1; e <= 6410; e++) begin
            @(negedge clk);
            obs.delete();
            if (f_video_on !== pv) begin
                obs.push_back('{(f_video_on ? EV_VID_RISE : EV_VID_FALL), e});
                if (!f_video_on) begin
                    total++;
                    if (f_x !== 10'd640) begin
                        bad++;
                        $display("FAIL line_vid_fall_x got=%0d exp=640", f_x);
                    end
                end
            end
            if (f_hsync !== ph) begin
                obs.push_back('{(f_hsync ? EV_HS_RISE : EV_HS_FALL), e});
                total++;
                if (f_x !== (f_hsync ? 10'd752 : 10'd656)) begin
                    bad++;
                    $display("FAIL line_hsync_x got=%0d exp=%0d", f_x, f_hsync ? 752 : 656);
                end
            end
            if (f_y !== py) begin
                obs.push_back('{EV_Y_CHG, e});
                y_chg.push_back(e);
            end
            pv = f_video_on;
            ph = f_hsync;
            py = f_y;
            while (obs.size() > 0) begin
                o = obs.pop_front();
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL line_event_extra kind=%0d edge=%0d exp=none", o.kind, o.cyc);
                end else begin
                    x = q.pop_front();
                    if (o.kind !== x.kind || o.cyc !== x.cyc) begin
                        bad++;
                        $display("FAIL line_event got kind=%0d edge=%0d exp kind=%0d edge=%0d",
                                 o.kind, o.cyc, x.kind, x.cyc);
                    end
                end
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL line_missing_events got=%0d exp=0", q.size());
        end
        total++;
        if (y_chg.size() < 2 || (y_chg[1] - y_chg[0]) != 3200) begin
            bad++;
            $display("FAIL line_period got=%0d exp=3200",
                     (y_chg.size() < 2) ? -1 : y_chg[1] - y_chg[0]);
        end
    endtask

    task automatic test_frame();
        ev_t q[$];
        ev_t obs[$];
        ev_t o, x;
        int von_cnt[4];
        int fe_cnt;
        int viol;
        logic pvs, pfe;
        logic [9:0] py;
        fe_cnt = 0;
        viol = 0;
        for (int f = 0; f < 4; f++) von_cnt[f] = 0;
        pulse_reset();
        pvs = s_vsync;
        pfe = s_frame_end;
        py  = s_y;
        for (int f = 0; f < 3; f++) begin
            q.push_back('{EV_VS_FALL, f * S_FRAME + 80 * 8});
            q.push_back('{EV_VS_RISE, f * S_FRAME + 80 * 10});
            q.push_back('{EV_FE_RISE, f * S_FRAME + 1039});
            q.push_back('{EV_FE_FALL, f * S_FRAME + 1040});
            q.push_back('{EV_Y_WRAP,  f * S_FRAME + 1040});
        end
        for (int e = 1; e <= 3130; e++) begin
            @(negedge clk);
            obs.delete();
            if (s_x >= 10'd20 || s_y >= 10'd13) viol++;
            if (s_p_tick && s_video_on) von_cnt[e / S_FRAME]++;
            if (s_vsync !== pvs) obs.push_back('{(s_vsync ? EV_VS_RISE : EV_VS_FALL), e});
            if (s_frame_end !== pfe) begin
                obs.push_back('{(s_frame_end ? EV_FE_RISE : EV_FE_FALL), e});
                if (s_frame_end) fe_cnt++;
            end
            if (s_y !== py && s_y == 10'd0) obs.push_back('{EV_Y_WRAP, e});
            pvs = s_vsync;
            pfe = s_frame_end;
            py  = s_y;
            while (obs.size() > 0) begin
                o = obs.pop_front();
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_event_extra kind=%0d edge=%0d exp=none", o.kind, o.cyc);
                end else begin
                    x = q.pop_front();
                    if (o.kind !== x.kind || o.cyc !== x.cyc) begin
                        bad++;
                        $display("FAIL frame_event got kind=%0d edge=%0d exp kind=%0d edge=%0d",
                                 o.kind, o.cyc, x.kind, x.cyc);
                    end
                end
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL frame_missing_events got=%0d exp=0", q.size());
        end
        total++;
        if (fe_cnt != 3) begin
            bad++;
            $display("FAIL frame_end_count got=%0d exp=3", fe_cnt);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL counter_range violations got=%0d exp=0", viol);
        end
        for (int f = 0; f < 3; f++) begin
            total++;
            if (von_cnt[f] != SH_DISP * SV_DISP) begin
                bad++;
                $display("FAIL visible_ticks frame=%0d got=%0d exp=%0d", f, von_cnt[f], SH_DISP * SV_DISP);
            end
        end
    endtask

    task automatic test_wrap();
        int early_fe;
        logic [24:0] exp_v;
        early_fe = 0;
        pulse_reset();
        for (int e = 1; e <= 1038; e++) begin
            @(negedge clk);
            if (s_frame_end) early_fe++;
        end
        total++;
        if (early_fe != 0) begin
            bad++;
            $display("FAIL wrap_early_frame_end got=%0d exp=0", early_fe);
        end
        @(negedge clk);
        exp_v = {1'b1, 10'd19, 10'd12, 1'b0, 1'b1, 1'b1, 1'b1};
        total++;
        if (s_vec() !== exp_v) begin
            bad++;
            $display("FAIL wrap_last_pixel got=%h exp=%h", s_vec(), exp_v);
        end
        @(negedge clk);
        exp_v = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        total++;
        if (s_vec() !== exp_v) begin
            bad++;
            $display("FAIL wrap_origin got=%h exp=%h", s_vec(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] q[$];
        logic [24:0] exp_v;
        int hit;
        hit = 0;
        pulse_reset();
        // (14,3) lies inside the scaled hsync window; its p_tick cycle is edge 299
        for (int e = 1; e <= 2000 && hit == 0; e++) begin
            @(negedge clk);
            if (s_x == 10'd14 && s_y == 10'd3 && s_p_tick) hit = e;
        end
        total++;
        if (hit != 299 || s_hsync !== 1'b0) begin
            bad++;
            $display("FAIL mid_reach got edge=%0d hsync=%b exp edge=299 hsync=0", hit, s_hsync);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_v = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        total++;
        if (s_vec() !== exp_v) begin
            bad++;
            $display("FAIL mid_reset_state got=%h exp=%h", s_vec(), exp_v);
        end
        reset = 1'b0;
        for (int k = 1; k <= 9; k++)
            q.push_back({(k % 4 == 3), 10'(k / 4), 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        for (int k = 1; q.size() > 0; k++) begin
            @(negedge clk);
            exp_v = q.pop_front();
            total++;
            if (s_vec() !== exp_v) begin
                bad++;
                $display("FAIL mid_release edge=%0d got=%h exp=%h", k, s_vec(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
